cmerge3_sync_nodata: RTL and testbench

Clocked 3-to-1 merge for the drive/free pulse handshake used by our no-data control channels. It is the converging counterpart of the 3-way selector: up to three upstream sources each raise a drive pulse. The block serialises them onto one downstream channel with round-robin arbitration and reports the winning source on a one-hot select. The completion (free) pulse is routed back to the source that was served.

---
 rtl/cmerge3_sync_nodata.sv | 156 +++++++++++++++
 tb/tb_cmerge3_sync_nodata.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmerge3_sync_nodata.sv
// Purpose : 3-to-1 round-robin merge of drive/free pulse handshakes onto one downstream channel.
// Latency : drive -> pending +1 cycle -> o_driveNext/o_select +2; i_freeNext -> o_freeK +1.
// Backpr. : one request in flight at a time; other sources wait in pend until the served one is freed.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   i_drive0..2 / o_free0..2  per-source request pulse in, completion pulse out
//   o_driveNext / i_freeNext  downstream request pulse out, completion pulse in
//   o_select                  one-hot id of the source being served (0 when idle)
//   o_pending                 registered per-source pending flags
//   o_err                     sticky protocol-violation flag
module cmerge3_sync_nodata #(
   parameter int NUM_PORTS = 3   // port list is fixed; only 3 is meaningful
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 i_drive0,
   input  logic                 i_drive1,
   input  logic                 i_drive2,
   output logic                 o_free0,
   output logic                 o_free1,
   output logic                 o_free2,
   output logic                 o_driveNext,
   input  logic                 i_freeNext,
   output logic [NUM_PORTS-1:0] o_select,
   output logic [NUM_PORTS-1:0] o_pending,
   output logic                 o_err
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [NUM_PORTS-1:0] pend_q, pend_d;
   logic [NUM_PORTS-1:0] sel_q, sel_d;
   logic [NUM_PORTS-1:0] free_q, free_d;
   logic [1:0]           last_q, last_d;
   logic [1:0]           serv_q, serv_d;
   logic                 drive_next_q, drive_next_d;
   logic                 err_q, err_d;

   logic [NUM_PORTS-1:0] req;
   logic [1:0]           cand0, cand1, cand2;
   logic [1:0]           win_idx;
   logic                 win_vld;
   logic [NUM_PORTS-1:0] win_oh;

   assign req = {i_drive2, i_drive1, i_drive0};

   // Round-robin pick: scan order starts one past the last served port.
   always_comb begin : rr_pick
      cand0 = 2'd0;
      cand1 = 2'd1;
      cand2 = 2'd2;
      case (last_q)
         2'd0: begin
            cand0 = 2'd1;
            cand1 = 2'd2;
            cand2 = 2'd0;
         end
         2'd1: begin
            cand0 = 2'd2;
            cand1 = 2'd0;
            cand2 = 2'd1;
         end
         default: ;
      endcase

      win_vld = |pend_q;
      if (pend_q[cand0]) begin
         win_idx = cand0;
      end else if (pend_q[cand1]) begin
         win_idx = cand1;
      end else begin
         win_idx = cand2;
      end

      case (win_idx)
         2'd0:    win_oh = 3'b001;
         2'd1:    win_oh = 3'b010;
         default: win_oh = 3'b100;
      endcase
   end

   always_comb begin : next_state
      state_d      = state_q;
      pend_d       = pend_q;
      sel_d        = sel_q;
      free_d       = '0;
      drive_next_d = 1'b0;
      last_d       = last_q;
      serv_d       = serv_q;
      err_d        = err_q;

      // A drive on an already-pending (or in-service) port, or a completion
      // with nothing outstanding, is a protocol violation.
      if ((|(req & pend_q)) || (i_freeNext && (state_q == ST_IDLE))) begin
         err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               state_d      = ST_BUSY;
               sel_d        = win_oh;
               serv_d       = win_idx;
               drive_next_d = 1'b1;
            end
         end
         default: begin
            if (i_freeNext) begin
               state_d = ST_IDLE;
               free_d  = sel_q;
               pend_d  = pend_q & ~sel_q;
               last_d  = serv_q;
               sel_d   = '0;
            end
         end
      endcase

      // Only drives on ports that were clear this cycle are recorded; a drive
      // landing on a port whose completion happens now is still a duplicate.
      pend_d = pend_d | (req & ~pend_q);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         pend_q       <= '0;
         sel_q        <= '0;
         free_q       <= '0;
         last_q       <= 2'd2;   // port 0 gets first priority out of reset
         serv_q       <= 2'd0;
         drive_next_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         sel_q        <= sel_d;
         free_q       <= free_d;
         last_q       <= last_d;
         serv_q       <= serv_d;
         drive_next_q <= drive_next_d;
         err_q        <= err_d;
      end
   end

   assign o_free0     = free_q[0];
   assign o_free1     = free_q[1];
   assign o_free2     = free_q[2];
   assign o_driveNext = drive_next_q;
   assign o_select    = sel_q;
   assign o_pending   = pend_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_cmerge3_sync_nodata.sv
// Purpose : randomized + directed check of cmerge3_sync_nodata against a behavioural model.
// Latency : n/a (bench).
// Backpr. : downstream completions are generated by the bench, immediately or after a delay.
module tb_cmerge3_sync_nodata;

   logic       clk;
   logic       rstn;
   logic       i_drive0, i_drive1, i_drive2;
   logic       o_free0, o_free1, o_free2;
   logic       o_driveNext;
   logic       i_freeNext;
   logic [2:0] o_select;
   logic [2:0] o_pending;
   logic       o_err;

   cmerge3_sync_nodata #(.NUM_PORTS(3)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_drive0   (i_drive0),
      .i_drive1   (i_drive1),
      .i_drive2   (i_drive2),
      .o_free0    (o_free0),
      .o_free1    (o_free1),
      .o_free2    (o_free2),
      .o_driveNext(o_driveNext),
      .i_freeNext (i_freeNext),
      .o_select   (o_select),
      .o_pending  (o_pending),
      .o_err      (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Behavioural model: set of waiting ports, the one in service, last served.
   bit [2:0] m_pend;
   bit       m_busy;
   int       m_srv;
   int       m_last;
   bit [2:0] m_sel;
   bit [2:0] m_free;
   bit       m_drv;
   bit       m_err;

   logic [2:0] gq[$];     // o_select value at each observed grant
   int         gcyc[$];   // cycle number of each observed grant
   logic [2:0] pq[$];
   logic [2:0] exp_p[4];
   bit         p;
   int         t0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_pend = '0; m_busy = 1'b0; m_srv = 0; m_last = 2;
      m_sel = '0; m_free = '0; m_drv = 1'b0; m_err = 1'b0;
   endfunction

   function automatic void model_step();
      bit [2:0] req;
      bit [2:0] old;
      bit       found;
      req = {i_drive2, i_drive1, i_drive0};
      old = m_pend;
      m_drv  = 1'b0;
      m_free = '0;
      if (i_freeNext && !m_busy) m_err = 1'b1;
      for (int k = 0; k < 3; k++) if (req[k] && old[k]) m_err = 1'b1;
      if (m_busy && i_freeNext) begin
         m_free[m_srv] = 1'b1;
         m_pend[m_srv] = 1'b0;
         m_last = m_srv;
         m_busy = 1'b0;
         m_sel  = '0;
      end else if (!m_busy && old != 0) begin
         found = 1'b0;
         for (int i = 1; i <= 3; i++) begin
            if (!found && old[(m_last + i) % 3]) begin
               m_srv = (m_last + i) % 3;
               found = 1'b1;
            end
         end
         m_busy = 1'b1;
         m_sel  = 3'(1 << m_srv);
         m_drv  = 1'b1;
      end
      for (int k = 0; k < 3; k++) if (req[k] && !old[k]) m_pend[k] = 1'b1;
   endfunction

   task automatic drive(input bit d0, input bit d1, input bit d2, input bit fn);
      i_drive0 = d0; i_drive1 = d1; i_drive2 = d2; i_freeNext = fn;
   endtask

   // One clock: inputs already set for this cycle; outputs checked 1 time unit after the edge.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      chk("select",  32'(o_select),  32'(m_sel));
      chk("pending", 32'(o_pending), 32'(m_pend));
      chk("drvnext", 32'(o_driveNext), 32'(m_drv));
      chk("free",    32'({o_free2, o_free1, o_free0}), 32'(m_free));
      chk("err",     32'(o_err),     32'(m_err));
      if (o_driveNext) begin
         gq.push_back(o_select);
         gcyc.push_back(cyc);
      end
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
   task automatic do_reset();
      #3;
      rstn = 1'b0;
      drive(0, 0, 0, 0);
      #1;
      model_reset();
      chk("rst_select",  32'(o_select),  32'd0);
      chk("rst_pending", 32'(o_pending), 32'd0);
      chk("rst_drvnext", 32'(o_driveNext), 32'd0);
      chk("rst_free",    32'({o_free2, o_free1, o_free0}), 32'd0);
      chk("rst_err",     32'(o_err),     32'd0);
      @(negedge clk);
      rstn = 1'b1;
      cycle();
      gq.delete();
      gcyc.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      drive(0, 0, 0, 0);
      model_reset();

      // Single request: drive1 at t, grant at t+2, completion at t+5, free1 at t+6.
      do_reset();
      repeat (3) cycle();
      drive(0, 1, 0, 0);
      t0 = cyc;
      cycle();
      drive(0, 0, 0, 0);
      cycle();
      chk("single_lat", 32'(cyc - t0), 32'd2);
      chk("single_drv", 32'(o_driveNext), 32'd1);
      chk("single_sel", 32'(o_select), 32'd2);
      cycle(); cycle(); cycle();
      drive(0, 0, 0, 1);
      cycle();
      drive(0, 0, 0, 0);
      chk("single_free1", 32'({o_free2, o_free1, o_free0}), 32'd2);
      chk("single_selclr", 32'(o_select), 32'd0);

      // Simultaneous requests, completion one cycle after each grant.
      do_reset();
      drive(1, 1, 1, 0);
      cycle();
      drive(0, 0, 0, 0);
      pq.delete();
      pq.push_back(o_pending);
      p = 1'b0;
      repeat (14) begin
         i_freeNext = p;
         p = o_driveNext;
         cycle();
         if (o_pending != pq[pq.size()-1]) pq.push_back(o_pending);
      end
      i_freeNext = 1'b0;
      chk("sim_gcnt", 32'(gq.size()), 32'd3);
      for (int i = 0; i < 3 && i < gq.size(); i++) chk("sim_gnt", 32'(gq[i]), 32'(1 << i));
      exp_p = '{3'b111, 3'b110, 3'b100, 3'b000};
      chk("sim_pcnt", 32'(pq.size()), 32'd4);
      for (int i = 0; i < 4 && i < pq.size(); i++) chk("sim_pend", 32'(pq[i]), 32'(exp_p[i]));

      // Fairness: ports 0 and 2 re-drive in their free cycles.
      do_reset();
      drive(1, 0, 1, 0);
      cycle();
      drive(0, 0, 0, 0);
      for (int n = 0; n < 80 && gq.size() < 6; n++) begin
         i_drive0   = o_free0;
         i_drive2   = o_free2;
         i_freeNext = o_driveNext;
         cycle();
      end
      drive(0, 0, 0, 0);
      chk("fair_gcnt", 32'(gq.size()), 32'd6);
      for (int i = 0; i < 6 && i < gq.size(); i++)
         chk("fair_gnt", 32'(gq[i]), (i % 2 == 0) ? 32'd1 : 32'd4);

      // Completion while idle: error, no free pulse.
      do_reset();
      drive(0, 0, 0, 1);
      cycle();
      drive(0, 0, 0, 0);
      chk("idlefree_err", 32'(o_err), 32'd1);
      chk("idlefree_nofree", 32'({o_free2, o_free1, o_free0}), 32'd0);
      repeat (3) cycle();

      // Double drive on port 0: only one grant, sticky error.
      do_reset();
      drive(1, 0, 0, 0);
      cycle();
      drive(1, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 0);
      chk("dbl_err", 32'(o_err), 32'd1);
      p = 1'b0;
      repeat (8) begin
         i_freeNext = p;
         p = o_driveNext;
         cycle();
      end
      i_freeNext = 1'b0;
      chk("dbl_gcnt", 32'(gq.size()), 32'd1);
      chk("dbl_err_held", 32'(o_err), 32'd1);

      // Reset between grant and completion with port 2 still pending.
      do_reset();
      drive(1, 0, 1, 0);
      cycle();
      drive(0, 0, 0, 0);
      cycle();
      chk("rm_pre_drv", 32'(o_driveNext), 32'd1);
      chk("rm_pre_pend", 32'(o_pending), 32'd5);
      do_reset();
      repeat (8) cycle();
      chk("rm_nogrant", 32'(gq.size()), 32'd0);

      // Zero-delay completion: next pending port granted two cycles later.
      do_reset();
      drive(1, 1, 0, 0);
      cycle();
      drive(0, 0, 0, 0);
      for (int n = 0; n < 20 && gq.size() < 2; n++) begin
         i_freeNext = o_driveNext;
         cycle();
      end
      i_freeNext = 1'b0;
      chk("zd_gcnt", 32'(gq.size()), 32'd2);
      if (gq.size() >= 2) begin
         chk("zd_gap", 32'(gcyc[1] - gcyc[0]), 32'd2);
         chk("zd_gnt0", 32'(gq[0]), 32'd1);
         chk("zd_gnt1", 32'(gq[1]), 32'd2);
      end

      // Random legal traffic: no error may appear.
      do_reset();
      repeat (400) begin
         i_drive0   = !m_pend[0] && ($urandom_range(0, 2) == 0);
         i_drive1   = !m_pend[1] && ($urandom_range(0, 2) == 0);
         i_drive2   = !m_pend[2] && ($urandom_range(0, 2) == 0);
         i_freeNext = m_busy && ($urandom_range(0, 1) == 0);
         cycle();
      end
      drive(0, 0, 0, 0);
      chk("rnd_clean_err", 32'(o_err), 32'd0);

      // Random traffic including violations and occasional resets.
      do_reset();
      repeat (400) begin
         if ($urandom_range(0, 96) == 0) do_reset();
         i_drive0   = ($urandom_range(0, 3) == 0);
         i_drive1   = ($urandom_range(0, 3) == 0);
         i_drive2   = ($urandom_range(0, 3) == 0);
         i_freeNext = ($urandom_range(0, 2) == 0);
         cycle();
      end
      drive(0, 0, 0, 0);
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
